cpu_bus_dma_sched: RTL

- Sequences the CPU memory bus between the 6502 core, OAM (sprite) DMA and APU DMC sample fetches.
- Sits between the cpu block and the external bus inside rp2a03. Snoops CPU writes to the DMA register, halts the core through its ready input, and drives bus address, data and direction while a DMA owns the bus.
- Keeps a get/put cycle parity so OAM and DMC reads land on get cycles.

---
 rtl/cpu_bus_dma_sched_if.sv | 28 ++
 rtl/cpu_bus_dma_sched.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cpu_bus_dma_sched_if.sv
// CPU/DMA bus bundle for cpu_bus_dma_sched: the scheduler sits on the slave
// modport, and the CPU core, memory bus and DMC unit drive the master side.
interface cpu_bus_dma_sched_if;
  logic        rdy_in;
  logic [15:0] cpu_a_in;
  logic [7:0]  cpu_d_in;
  logic        cpu_r_nw_in;
  logic [7:0]  bus_d_in;
  logic        dmc_req_in;
  logic [15:0] dmc_a_in;
  logic        cpu_ready_out;
  logic [15:0] a_out;
  logic [7:0]  d_out;
  logic        r_nw_out;
  logic        dmc_ack_out;
  logic [7:0]  dmc_d_out;
  logic        oam_active_out;

  modport slave (
    input  rdy_in, cpu_a_in, cpu_d_in, cpu_r_nw_in, bus_d_in, dmc_req_in, dmc_a_in,
    output cpu_ready_out, a_out, d_out, r_nw_out, dmc_ack_out, dmc_d_out, oam_active_out
  );

  modport master (
    output rdy_in, cpu_a_in, cpu_d_in, cpu_r_nw_in, bus_d_in, dmc_req_in, dmc_a_in,
    input  cpu_ready_out, a_out, d_out, r_nw_out, dmc_ack_out, dmc_d_out, oam_active_out
  );
endinterface

// File: rtl/cpu_bus_dma_sched.sv
// Arbitrates the CPU memory bus between the 6502 core, OAM DMA and DMC fetches.
// Define DMA_PARITY_ALIGN_EN to keep DMA reads on get cycles using a parity bit.
module cpu_bus_dma_sched #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input logic                clk_in,
  input logic                nrst_in,
  cpu_bus_dma_sched_if.slave bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_OAM_HALT  = 3'd1;
  localparam logic [2:0] S_OAM_ALIGN = 3'd2;
  localparam logic [2:0] S_OAM_READ  = 3'd3;
  localparam logic [2:0] S_OAM_WRITE = 3'd4;
  localparam logic [2:0] S_DMC_HALT  = 3'd5;
  localparam logic [2:0] S_DMC_ALIGN = 3'd6;
  localparam logic [2:0] S_DMC_READ  = 3'd7;

  logic [2:0] state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] page_q, page_d;
  logic [7:0] buf_q, buf_d;
  logic       oam_q, oam_d;
  logic       dmc_ack_q, dmc_ack_d;
  logic [7:0] dmc_d_q, dmc_d_d;
`ifdef DMA_PARITY_ALIGN_EN
  logic       parity_q;
`endif

  logic oam_trig;
  logic dmc_req;

  assign oam_trig = (bus.cpu_a_in == DMA_REG_ADDR) && !bus.cpu_r_nw_in;
  // The requester still holds its level during the ack cycle; masking it
  // there prevents a second fetch for the same request.
  assign dmc_req  = bus.dmc_req_in && !dmc_ack_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    page_d    = page_q;
    buf_d     = buf_q;
    oam_d     = oam_q;
    dmc_ack_d = 1'b0;
    dmc_d_d   = dmc_d_q;
    case (state_q)
      S_IDLE: begin
        if (oam_trig) begin
          page_d  = bus.cpu_d_in;
          count_d = 8'd0;
          oam_d   = 1'b1;
          state_d = S_OAM_HALT;
        end else if (dmc_req) begin
          state_d = S_DMC_HALT;
        end
      end
`ifdef DMA_PARITY_ALIGN_EN
      S_OAM_HALT:  state_d = parity_q ? S_OAM_READ : S_OAM_ALIGN;
      S_DMC_HALT:  state_d = parity_q ? S_DMC_READ : S_DMC_ALIGN;
`else
      S_OAM_HALT:  state_d = S_OAM_READ;
      S_DMC_HALT:  state_d = S_DMC_READ;
`endif
      S_OAM_ALIGN: state_d = S_OAM_READ;
      S_DMC_ALIGN: state_d = S_DMC_READ;
      S_OAM_READ: begin
        buf_d   = bus.bus_d_in;
        state_d = S_OAM_WRITE;
      end
      S_OAM_WRITE: begin
        count_d = count_q + 8'd1;
        if (count_q == 8'hFF) begin
          oam_d   = 1'b0;
          state_d = S_IDLE;
        end else if (dmc_req) begin
          state_d = S_DMC_READ;
        end else begin
          state_d = S_OAM_READ;
        end
      end
      S_DMC_READ: begin
        dmc_d_d   = bus.bus_d_in;
        dmc_ack_d = 1'b1;
`ifdef DMA_PARITY_ALIGN_EN
        state_d   = oam_q ? S_OAM_ALIGN : S_IDLE;
`else
        state_d   = oam_q ? S_OAM_READ : S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q   <= S_IDLE;
      count_q   <= 8'd0;
      page_q    <= 8'd0;
      buf_q     <= 8'd0;
      oam_q     <= 1'b0;
      dmc_ack_q <= 1'b0;
      dmc_d_q   <= 8'd0;
`ifdef DMA_PARITY_ALIGN_EN
      parity_q  <= 1'b0;
`endif
    end else if (bus.rdy_in) begin
      state_q   <= state_d;
      count_q   <= count_d;
      page_q    <= page_d;
      buf_q     <= buf_d;
      oam_q     <= oam_d;
      dmc_ack_q <= dmc_ack_d;
      dmc_d_q   <= dmc_d_d;
`ifdef DMA_PARITY_ALIGN_EN
      parity_q  <= ~parity_q;
`endif
    end
  end

  // Halt and align states issue a dummy read at the CPU's address.
  always_comb begin
    bus.a_out    = bus.cpu_a_in;
    bus.d_out    = bus.cpu_d_in;
    bus.r_nw_out = 1'b1;
    case (state_q)
      S_IDLE:      bus.r_nw_out = bus.cpu_r_nw_in;
      S_OAM_READ:  bus.a_out    = {page_q, count_q};
      S_OAM_WRITE: begin
        bus.a_out    = OAM_DATA_ADDR;
        bus.d_out    = buf_q;
        bus.r_nw_out = 1'b0;
      end
      S_DMC_READ:  bus.a_out    = bus.dmc_a_in;
      default:     bus.r_nw_out = 1'b1;
    endcase
  end

  assign bus.cpu_ready_out  = bus.rdy_in && (state_q == S_IDLE);
  assign bus.oam_active_out = oam_q;
  assign bus.dmc_ack_out    = dmc_ack_q;
  assign bus.dmc_d_out      = dmc_d_q;

endmodule
